// File: rtl/l2req_core_arbiter_pkg.sv
// rtl/l2req_core_arbiter_pkg.sv - shared L2 request field widths, request record and arbiter state type
// Field widths mirror the l2_cache.h request layout.
package l2req_core_arbiter_pkg;

  localparam int L2_STRAND_W  = 2;
  localparam int L2_UNIT_W    = 2;
  localparam int L2_OP_W      = 3;
  localparam int L2_WAY_W     = 2;
  localparam int L2_ADDRESS_W = 26;
  localparam int L2_DATA_W    = 512;
  localparam int L2_MASK_W    = 64;

  typedef struct packed {
    logic [L2_STRAND_W-1:0]  strand;
    logic [L2_UNIT_W-1:0]    unit;
    logic [L2_OP_W-1:0]      op;
    logic [L2_WAY_W-1:0]     way;
    logic [L2_ADDRESS_W-1:0] address;
    logic [L2_DATA_W-1:0]    data;
    logic [L2_MASK_W-1:0]    mask;
  } l2req_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/l2req_core_arbiter_if.sv
// rtl/l2req_core_arbiter_if.sv - core-side request/response bundle and shared L2 port
// slave is the arbiter's view; master is the cores-plus-L2 environment's view.
interface l2req_core_arbiter_if
  import l2req_core_arbiter_pkg::*;
#(
  parameter int NUM_CORES     = 4,
  parameter int CORE_ID_WIDTH = 2
);

  logic [NUM_CORES-1:0]              core_l2req_valid;
  logic [NUM_CORES-1:0]              core_l2req_ack;
  logic [NUM_CORES*L2_STRAND_W-1:0]  core_l2req_strand;
  logic [NUM_CORES*L2_UNIT_W-1:0]    core_l2req_unit;
  logic [NUM_CORES*L2_OP_W-1:0]      core_l2req_op;
  logic [NUM_CORES*L2_WAY_W-1:0]     core_l2req_way;
  logic [NUM_CORES*L2_ADDRESS_W-1:0] core_l2req_address;
  logic [NUM_CORES*L2_DATA_W-1:0]    core_l2req_data;
  logic [NUM_CORES*L2_MASK_W-1:0]    core_l2req_mask;

  logic                     l2req_valid;
  logic                     l2req_ack;
  logic [CORE_ID_WIDTH-1:0] l2req_core;
  logic [L2_STRAND_W-1:0]   l2req_strand;
  logic [L2_UNIT_W-1:0]     l2req_unit;
  logic [L2_OP_W-1:0]       l2req_op;
  logic [L2_WAY_W-1:0]      l2req_way;
  logic [L2_ADDRESS_W-1:0]  l2req_address;
  logic [L2_DATA_W-1:0]     l2req_data;
  logic [L2_MASK_W-1:0]     l2req_mask;

  logic                     l2rsp_valid;
  logic [CORE_ID_WIDTH-1:0] l2rsp_core;
  logic [NUM_CORES-1:0]     core_l2rsp_valid;

  modport slave (
    input  core_l2req_valid, core_l2req_strand, core_l2req_unit, core_l2req_op,
           core_l2req_way, core_l2req_address, core_l2req_data, core_l2req_mask,
           l2req_ack, l2rsp_valid, l2rsp_core,
    output core_l2req_ack, l2req_valid, l2req_core, l2req_strand, l2req_unit,
           l2req_op, l2req_way, l2req_address, l2req_data, l2req_mask,
           core_l2rsp_valid
  );

  modport master (
    output core_l2req_valid, core_l2req_strand, core_l2req_unit, core_l2req_op,
           core_l2req_way, core_l2req_address, core_l2req_data, core_l2req_mask,
           l2req_ack, l2rsp_valid, l2rsp_core,
    input  core_l2req_ack, l2req_valid, l2req_core, l2req_strand, l2req_unit,
           l2req_op, l2req_way, l2req_address, l2req_data, l2req_mask,
           core_l2rsp_valid
  );

endinterface

// File: rtl/l2req_core_arbiter_rr_grant_select.sv
// rtl/l2req_core_arbiter_rr_grant_select.sv - picks the first valid core at or above ptr, wrapping
// A zero ptr degenerates to fixed priority with core 0 highest.
module rr_grant_select #(
  parameter int NUM_CORES     = 4,
  parameter int CORE_ID_WIDTH = 2
) (
  input  logic [NUM_CORES-1:0]     valid,
  input  logic [CORE_ID_WIDTH-1:0] ptr,
  output logic [NUM_CORES-1:0]     grant,
  output logic [CORE_ID_WIDTH-1:0] grant_idx,
  output logic                     grant_any
);

  int cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = (int'(ptr) + i) % NUM_CORES;
      if (!grant_any && valid[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = CORE_ID_WIDTH'(cand);
      end
    end
  end

endmodule

// File: rtl/l2req_core_arbiter.sv
// rtl/l2req_core_arbiter.sv - N-core to one L2 request port arbiter with response fan-out
// Optional build macro: L2REQ_ARB_ROUND_ROBIN_EN (round-robin instead of fixed priority).
module l2req_core_arbiter
  import l2req_core_arbiter_pkg::*;
#(
  parameter int NUM_CORES     = 4,
  parameter int CORE_ID_WIDTH = 2
) (
  input logic               clk,
  input logic               reset,
  l2req_core_arbiter_if.slave bus
);

  arb_state_t               state;
  logic [CORE_ID_WIDTH-1:0] ptr;
  logic [NUM_CORES-1:0]     gnt;
  logic [CORE_ID_WIDTH-1:0] gidx;
  logic                     gany;
  logic                     grant_en;
  l2req_t                   sel_req;
  l2req_t                   req_q;
  logic [CORE_ID_WIDTH-1:0] core_q;
  logic                     valid_q;

  rr_grant_select #(
    .NUM_CORES     (NUM_CORES),
    .CORE_ID_WIDTH (CORE_ID_WIDTH)
  ) u_grant (
    .valid     (bus.core_l2req_valid),
    .ptr       (ptr),
    .grant     (gnt),
    .grant_idx (gidx),
    .grant_any (gany)
  );

  // The output register is free when empty or when L2 is taking its content this cycle.
  assign grant_en           = !reset && gany && ((state == ARB_IDLE) || bus.l2req_ack);
  assign bus.core_l2req_ack = grant_en ? gnt : '0;

  always_comb begin
    sel_req         = '0;
    sel_req.strand  = bus.core_l2req_strand [gidx*L2_STRAND_W  +: L2_STRAND_W];
    sel_req.unit    = bus.core_l2req_unit   [gidx*L2_UNIT_W    +: L2_UNIT_W];
    sel_req.op      = bus.core_l2req_op     [gidx*L2_OP_W      +: L2_OP_W];
    sel_req.way     = bus.core_l2req_way    [gidx*L2_WAY_W     +: L2_WAY_W];
    sel_req.address = bus.core_l2req_address[gidx*L2_ADDRESS_W +: L2_ADDRESS_W];
    sel_req.data    = bus.core_l2req_data   [gidx*L2_DATA_W    +: L2_DATA_W];
    sel_req.mask    = bus.core_l2req_mask   [gidx*L2_MASK_W    +: L2_MASK_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ARB_IDLE;
      valid_q <= 1'b0;
      req_q   <= '0;
      core_q  <= '0;
    end else if (grant_en) begin
      state   <= ARB_BUSY;
      valid_q <= 1'b1;
      req_q   <= sel_req;
      core_q  <= gidx;
    end else if ((state == ARB_BUSY) && bus.l2req_ack) begin
      state   <= ARB_IDLE;
      valid_q <= 1'b0;
    end
  end

`ifdef L2REQ_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (grant_en) begin
      ptr <= (int'(gidx) == NUM_CORES - 1) ? '0 : gidx + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  assign bus.l2req_valid   = valid_q;
  assign bus.l2req_core    = core_q;
  assign bus.l2req_strand  = req_q.strand;
  assign bus.l2req_unit    = req_q.unit;
  assign bus.l2req_op      = req_q.op;
  assign bus.l2req_way     = req_q.way;
  assign bus.l2req_address = req_q.address;
  assign bus.l2req_data    = req_q.data;
  assign bus.l2req_mask    = req_q.mask;

  // Out-of-range response targets match no k and so assert nothing.
  always_comb begin
    bus.core_l2rsp_valid = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      bus.core_l2rsp_valid[k] = bus.l2rsp_valid && (bus.l2rsp_core == CORE_ID_WIDTH'(k));
    end
  end

endmodule
